// File: rtl/mult_share_pkg.sv
// Shared constants for the two-client multiplier arbiter: default operand
// width, requester ids and the product width rule.
package mult_share_pkg;

  localparam int N_DEFAULT = 4;

  typedef logic req_id_t;

  localparam req_id_t ID_REQ0 = 1'b0;
  localparam req_id_t ID_REQ1 = 1'b1;

  // Full-width product: no truncation for any unsigned operand pair.
  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/response bundle between the two operand sources and the arbiter.
// master = requester side, slave = arbiter side.
interface mult_share_arb_if
  import mult_share_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [N-1:0]          req0_a;
  logic [N-1:0]          req0_b;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [N-1:0]          req1_a;
  logic [N-1:0]          req1_b;

  logic                  rsp_valid;
  req_id_t               rsp_id;
  logic [prod_w(N)-1:0]  rsp_p;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/mult_n.sv
// Combinational unsigned array multiplier: one shifted partial product per
// bit of b, accumulated row by row.
module mult_n #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic [2*N-1:0] pp;
    logic [2*N-1:0] sum;

    assign pp = b[gi] ? ({{N{1'b0}}, a} << gi) : '0;

    if (gi == 0) begin : g_first
      assign sum = pp;
    end else begin : g_acc
      assign sum = g_row[gi-1].sum + pp;
    end
  end

  assign p = g_row[N-1].sum;

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one mult_n between two requesters, with
// registered operands (S1) and a registered, id-tagged product (S2).
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  mult_share_arb_if.slave  bus
);

  localparam int PW = prod_w(N);

  logic            prio_reg;
  logic            s1_v_reg;
  req_id_t         s1_id_reg;
  logic [N-1:0]    s1_a_reg;
  logic [N-1:0]    s1_b_reg;
  logic            rsp_valid_reg;
  req_id_t         rsp_id_reg;
  logic [PW-1:0]   rsp_p_reg;

  logic            grant0;
  logic            grant1;
  logic            grant_any;
  req_id_t         grant_id;
  logic [N-1:0]    grant_a;
  logic [N-1:0]    grant_b;
  logic [PW-1:0]   mult_p;

  // A lone requester wins outright; on contention prio picks the winner.
  // Grants are suppressed while reset is held so nothing is accepted then.
  always_comb begin
    grant0    = bus.req0_valid & ~reset & (~bus.req1_valid | (prio_reg == ID_REQ0));
    grant1    = bus.req1_valid & ~reset & (~bus.req0_valid | (prio_reg == ID_REQ1));
    grant_any = grant0 | grant1;
    grant_id  = grant1 ? ID_REQ1 : ID_REQ0;
    grant_a   = grant1 ? bus.req1_a : bus.req0_a;
    grant_b   = grant1 ? bus.req1_b : bus.req0_b;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg  <= ID_REQ0;
      s1_v_reg  <= 1'b0;
      s1_id_reg <= ID_REQ0;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
    end else begin
      s1_v_reg <= grant_any;
      if (grant_any) begin
        prio_reg  <= ~grant_id;
        s1_id_reg <= grant_id;
        s1_a_reg  <= grant_a;
        s1_b_reg  <= grant_b;
      end
    end
  end

  mult_n #(
    .N (N)
  ) u_mult (
    .a (s1_a_reg),
    .b (s1_b_reg),
    .p (mult_p)
  );

  // Id and product hold between responses; only rsp_valid marks new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= ID_REQ0;
      rsp_p_reg     <= '0;
    end else begin
      rsp_valid_reg <= s1_v_reg;
      if (s1_v_reg) begin
        rsp_id_reg <= s1_id_reg;
        rsp_p_reg  <= mult_p;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_p     = rsp_p_reg;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: reset, single transfer, contention,
// streaming, mid-flight reset and an exhaustive 4x4 sweep.
module tb_mult_share_arb;

  localparam int N = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mult_share_arb_if #(.N(N)) bus ();

  mult_share_arb #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check ready and response at the falling edge,
  // then advance to just after the next rising edge.
  task automatic run(input string tag,
                     input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                     input logic v1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                     input logic er0, input logic er1,
                     input logic erv, input logic eid, input logic [2*N-1:0] ep);
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    @(negedge clk);
    chk({tag, ".req0_ready"}, 16'(bus.req0_ready), 16'(er0));
    chk({tag, ".req1_ready"}, 16'(bus.req1_ready), 16'(er1));
    chk({tag, ".rsp_valid"},  16'(bus.rsp_valid),  16'(erv));
    if (erv) begin
      chk({tag, ".rsp_id"}, 16'(bus.rsp_id), 16'(eid));
      chk({tag, ".rsp_p"},  16'(bus.rsp_p),  16'(ep));
      $display("%s: rsp id=%0d p=%0d (expected id=%0d p=%0d)",
               tag, bus.rsp_id, bus.rsp_p, eid, ep);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;

    // Reset held with random traffic: nothing granted, outputs cleared.
    for (int k = 0; k < 3; k++) begin
      bus.req0_valid = 1'($urandom);
      bus.req0_a     = N'($urandom);
      bus.req0_b     = N'($urandom);
      bus.req1_valid = 1'($urandom);
      bus.req1_a     = N'($urandom);
      bus.req1_b     = N'($urandom);
      @(negedge clk);
      chk("rst.req0_ready", 16'(bus.req0_ready), 16'd0);
      chk("rst.req1_ready", 16'(bus.req1_ready), 16'd0);
      chk("rst.rsp_valid",  16'(bus.rsp_valid),  16'd0);
      chk("rst.rsp_id",     16'(bus.rsp_id),     16'd0);
      chk("rst.rsp_p",      16'(bus.rsp_p),      16'd0);
      $display("reset cycle %0d: rsp_valid=%0d rsp_p=%0d", k, bus.rsp_valid, bus.rsp_p);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // Single transfer 3*5, ready the same cycle reset is released.
    run("single.c0", 1, 3, 5, 0, 0, 0, 1, 0, 0, 0, 0);
    run("single.c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run("single.c2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 15);
    run("single.c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // prio is now 1: a lone req1 grant returns it to 0 before contention.
    run("prep.c0",   0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0);
    run("cont.c0",   1, 15, 15, 1, 2, 7, 1, 0, 0, 0, 0);
    run("cont.c1",   1, 15, 15, 1, 2, 7, 0, 1, 1, 1, 2);
    run("cont.c2",   1, 15, 15, 1, 2, 7, 1, 0, 1, 0, 225);
    run("cont.c3",   1, 15, 15, 1, 2, 7, 0, 1, 1, 1, 14);
    run("cont.c4",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 225);
    run("cont.c5",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 14);
    run("cont.c6",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // req1 alone streams every cycle even though prio is 0.
    run("strm.c0",   0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    run("strm.c1",   0, 0, 0, 1, 2, 3, 0, 1, 0, 0, 0);
    run("strm.c2",   0, 0, 0, 1, 4, 4, 0, 1, 1, 1, 1);
    run("strm.c3",   0, 0, 0, 1, 15, 1, 0, 1, 1, 1, 6);
    run("strm.c4",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16);
    run("strm.c5",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 15);
    run("strm.c6",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-flight reset: 9*9 accepted (prio -> 1), then an async pulse.
    run("mid.c0",    1, 9, 9, 0, 0, 0, 1, 0, 0, 0, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("mid.rst.rsp_valid", 16'(bus.rsp_valid), 16'd0);
    chk("mid.rst.rsp_p",     16'(bus.rsp_p),     16'd0);
    reset = 1'b0;
    $display("mid: async reset pulse applied");
    @(posedge clk);
    #1;
    run("mid.c2",    1, 1, 1, 1, 2, 2, 1, 0, 0, 0, 0);
    run("mid.c3",    1, 1, 1, 1, 2, 2, 0, 1, 0, 0, 0);
    run("mid.c4",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    run("mid.c5",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
    run("mid.c6",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // All 256 pairs back-to-back on req0; result k lands two cycles later.
    for (int k = 0; k < 259; k++) begin
      logic          drv;
      logic          erv;
      logic [N-1:0]  a;
      logic [N-1:0]  b;
      logic [N-1:0]  ea;
      logic [N-1:0]  eb;
      drv = (k < 256);
      erv = (k >= 2) && (k < 258);
      a   = N'(k >> 4);
      b   = N'(k & 15);
      ea  = N'((k - 2) >> 4);
      eb  = N'((k - 2) & 15);
      run($sformatf("sweep.%0d", k), drv, a, b, 0, 0, 0, drv, 0,
          erv, 0, (2*N)'(ea) * (2*N)'(eb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
